// File: rtl/sdcard_sdram_writer.sv
// sdcard_sdram_writer
//   Write-side feeder for the SDRAM access arbiter. Packs the SD-card byte
//   stream into 16-bit words and buffers them in a small FIFO. Each word is
//   issued as a single write to the arbiter. Address, data and request are
//   held until the arbiter acknowledges. The media region is a ping-pong
//   buffer split on word-address bit HALF_BIT. After one half has been
//   filled, writing pauses until sd_write_resume reports that playback has
//   moved into the other half.
//
// Parameters
//   FIFO_DEPTH : word entries in the packing FIFO (power of two, >= 2)
//   HALF_BIT   : word-address bit selecting the ping-pong half
//   BASE_ADDR  : region base; bits [HALF_BIT:0] must be zero
//
// Ports
//   clk50            in   system clock
//   reset_n          in   synchronous active-low reset
//   start            in   pulse: begin streaming at BASE_ADDR (IDLE only)
//   abort            in   pulse: flush and return to idle
//   sd_byte          in   [7:0] byte from the SD reader
//   sd_byte_valid    in   sd_byte valid this cycle
//   sd_byte_ready    out  byte accepted when valid && ready
//   sd_write_resume  in   readers have crossed into the other half
//   addr_out_write   out  [25:0] word address to the arbiter
//   write_out        out  write request to the arbiter
//   writedata_out    out  [15:0] write data
//   ack_in_write     in   write acknowledge from the arbiter
//   active           out  state != IDLE
//   paused           out  state == WAIT_HALF
//
// Build option
//   SDW_BYTESWAP_EN : when defined, the first byte of each pair is placed in
//                     [15:8] (big-endian sample order); otherwise in [7:0].
//
// State    | meaning
// ---------+---------------------------------------------------------
// IDLE     | not streaming; no bytes accepted, no writes
// RUN      | accepting bytes, writing FIFO head whenever FIFO non-empty
// WAIT_HALF| current half filled; bytes accepted, writes held off

module sdcard_sdram_writer #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          HALF_BIT   = 23,
  parameter logic [25:0] BASE_ADDR  = 26'h0
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  sd_byte,
  input  logic        sd_byte_valid,
  output logic        sd_byte_ready,
  input  logic        sd_write_resume,
  output logic [25:0] addr_out_write,
  output logic        write_out,
  output logic [15:0] writedata_out,
  input  logic        ack_in_write,
  output logic        active,
  output logic        paused
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  // Address bits that advance within the region; the rest stay at BASE_ADDR.
  localparam logic [25:0]   LOW_MASK = 26'((64'd1 << (HALF_BIT + 1)) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_WAIT_HALF = 2'd2
  } state_t;

  state_t        r_state;
  logic [25:0]   r_addr;
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_lat;
  logic          r_lat_valid;
  logic          r_write;

  logic          w_ready;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_next_has_data;
  logic [15:0]   w_word;
  logic [25:0]   w_addr_inc;
  logic          w_half_cross;

  // Ready uses the registered count only, so a full FIFO refuses bytes even
  // in the cycle it is being popped.
  assign w_ready  = (r_state != S_IDLE) && (r_count < DEPTH_C);
  assign w_accept = sd_byte_valid && w_ready;
  assign w_push   = w_accept && r_lat_valid;
  assign w_pop    = r_write && ack_in_write;

  // FIFO holds data next cycle if it is non-empty now or a word lands now;
  // a pop cannot empty it here because the ack cycle never re-requests.
  assign w_next_has_data = (r_count != '0) || w_push;

`ifdef SDW_BYTESWAP_EN
  assign w_word = {r_lat, sd_byte};
`else
  assign w_word = {sd_byte, r_lat};
`endif

  assign w_addr_inc   = (r_addr & ~LOW_MASK) | ((r_addr + 26'd1) & LOW_MASK);
  // Covers both the mid-region crossing and the wrap back to offset 0.
  assign w_half_cross = w_addr_inc[HALF_BIT] != r_addr[HALF_BIT];

  always_ff @(posedge clk50) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_lat       <= '0;
      r_lat_valid <= 1'b0;
      r_write     <= 1'b0;
    end else if (abort) begin
      // Abort dominates start, ack and resume; the address is left as is.
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_lat_valid <= 1'b0;
      r_write     <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_lat_valid) begin
          r_lat_valid <= 1'b0;
          r_wptr      <= r_wptr + 1'b1;
        end else begin
          r_lat       <= sd_byte;
          r_lat_valid <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      case (r_state)
        S_IDLE: begin
          r_write <= 1'b0;
          if (start) begin
            r_state     <= S_RUN;
            r_addr      <= BASE_ADDR;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_lat_valid <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_pop) begin
            r_addr  <= w_addr_inc;
            r_write <= 1'b0;
            if (w_half_cross) begin
              r_state <= S_WAIT_HALF;
            end
          end else begin
            r_write <= w_next_has_data;
          end
        end
        S_WAIT_HALF: begin
          if (sd_write_resume) begin
            r_state <= S_RUN;
            r_write <= w_next_has_data;
          end else begin
            r_write <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_write <= 1'b0;
        end
      endcase
    end
  end

  assign sd_byte_ready  = w_ready;
  assign write_out      = r_write;
  assign writedata_out  = r_write ? r_mem[r_rptr] : 16'h0000;
  assign addr_out_write = r_addr;
  assign active         = r_state != S_IDLE;
  assign paused         = r_state == S_WAIT_HALF;

endmodule

// File: tb/tb_sdcard_sdram_writer.sv
module tb_sdcard_sdram_writer;

  localparam int          DEPTH  = 8;
  localparam int          HB     = 3;
  localparam logic [25:0] BASE   = 26'h0000340;
  localparam int          REGION = 16;
  localparam int          HALF   = 8;

  logic        clk50 = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [7:0]  sd_byte;
  logic        sd_byte_valid;
  logic        sd_byte_ready;
  logic        sd_write_resume;
  logic [25:0] addr_out_write;
  logic        write_out;
  logic [15:0] writedata_out;
  logic        ack_in_write;
  logic        active;
  logic        paused;

  always #10 clk50 = ~clk50;

  sdcard_sdram_writer #(
    .FIFO_DEPTH(DEPTH),
    .HALF_BIT  (HB),
    .BASE_ADDR (BASE)
  ) dut (
    .clk50          (clk50),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .sd_byte        (sd_byte),
    .sd_byte_valid  (sd_byte_valid),
    .sd_byte_ready  (sd_byte_ready),
    .sd_write_resume(sd_write_resume),
    .addr_out_write (addr_out_write),
    .write_out      (write_out),
    .writedata_out  (writedata_out),
    .ack_in_write   (ack_in_write),
    .active         (active),
    .paused         (paused)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode, words waiting to be written, odd byte, the
  // expected request line and the current word address.
  int          m_state = 0;        // 0 idle, 1 streaming, 2 waiting for half
  logic [15:0] m_q[$];
  bit          m_lat_v = 0;
  logic [7:0]  m_lat   = 8'h00;
  bit          m_wr    = 0;
  logic [25:0] m_addr  = 26'h0;
  bit          m_zero_data = 1;

  function automatic logic [15:0] pack(input logic [7:0] first, input logic [7:0] second);
`ifdef SDW_BYTESWAP_EN
    return {first, second};
`else
    return {second, first};
`endif
  endfunction

  task automatic check_outputs();
    bit exp_ready;
    exp_ready = (m_state != 0) && (m_q.size() < DEPTH);
    chk("ready",     32'(sd_byte_ready),  32'(exp_ready));
    chk("write_out", 32'(write_out),      32'(m_wr));
    chk("active",    32'(active),         32'(m_state != 0));
    chk("paused",    32'(paused),         32'(m_state == 2));
    chk("addr",      32'(addr_out_write), 32'(m_addr));
    if (m_wr)
      chk("wdata", 32'(writedata_out), 32'(m_q[0]));
    else if (m_zero_data)
      chk("wdata_rst", 32'(writedata_out), 32'h0);
  endtask

  task automatic step(input bit rst, input bit st, input bit ab, input bit vld,
                      input logic [7:0] b, input bit ack, input bit res);
    bit exp_ready;
    bit pop;
    int old_state;
    int off;
    check_outputs();
    reset_n         = !rst;
    start           = st;
    abort           = ab;
    sd_byte_valid   = vld;
    sd_byte         = b;
    ack_in_write    = ack;
    sd_write_resume = res;
    exp_ready = (m_state != 0) && (m_q.size() < DEPTH);
    old_state = m_state;
    if (rst) begin
      m_state = 0; m_q.delete(); m_lat_v = 0; m_wr = 0; m_addr = 26'h0; m_zero_data = 1;
    end else if (ab) begin
      m_state = 0; m_q.delete(); m_lat_v = 0; m_wr = 0; m_zero_data = 0;
    end else begin
      m_zero_data = 0;
      pop = m_wr && ack;
      if (pop) begin
        void'(m_q.pop_front());
        off    = (int'(m_addr - BASE) + 1) % REGION;
        m_addr = BASE + 26'(off);
        if (off % HALF == 0) m_state = 2;
      end
      if (vld && exp_ready) begin
        if (m_lat_v) begin
          m_q.push_back(pack(m_lat, b));
          m_lat_v = 0;
        end else begin
          m_lat = b; m_lat_v = 1;
        end
      end
      if (old_state == 0 && st) begin
        m_state = 1; m_addr = BASE; m_q.delete(); m_lat_v = 0;
      end
      if (old_state == 2 && res) m_state = 1;
      m_wr = !pop && (m_state == 1) && (m_q.size() > 0);
    end
    @(negedge clk50);
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic rand_phase(input int n, input int p_vld, input int p_ack,
                            input int p_res, input int p_ab, input int p_st);
    for (int i = 0; i < n; i++) begin
      step(0, (m_state == 0) ? pct(p_st) : pct(3), pct(p_ab), pct(p_vld),
           8'($urandom_range(255)), pct(p_ack), pct(p_res));
    end
  endtask

  initial begin
    logic [7:0]  tp_bytes [4];
    logic [15:0] tp_words [2];
    int          w;
    int          nacks;
    bit          ack;
    bit          found;
    logic [25:0] a_before;

    tp_bytes[0] = 8'h34; tp_bytes[1] = 8'h12; tp_bytes[2] = 8'h78; tp_bytes[3] = 8'h56;
`ifdef SDW_BYTESWAP_EN
    tp_words[0] = 16'h3412; tp_words[1] = 16'h7856;
`else
    tp_words[0] = 16'h1234; tp_words[1] = 16'h5678;
`endif

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; sd_byte = 8'h00; sd_byte_valid = 1'b0;
    sd_write_resume = 1'b0; ack_in_write = 1'b0;
    repeat (2) @(posedge clk50);
    @(negedge clk50);

    // Basic stream: two words, each acked after three wait cycles.
    step(0, 0, 0, 0, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, tp_bytes[i], 0, 0);
    w = 0; nacks = 0;
    for (int i = 0; i < 30; i++) begin
      w   = m_wr ? w + 1 : 0;
      ack = (w == 4);
      if (ack && nacks < 2) begin
        chk("tp_word", 32'(writedata_out), 32'(tp_words[nacks]));
        chk("tp_addr", 32'(addr_out_write), 32'(BASE + 26'(nacks)));
        nacks++;
      end
      step(0, 0, 0, 0, 8'h00, ack, 0);
    end
    chk("tp_acks", 32'(nacks), 32'd2);

    // Fill the FIFO with no acks, then pop a single word.
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 8'($urandom_range(255)), 0, 0);
    chk("full_ready", 32'(sd_byte_ready), 32'd0);
    step(0, 0, 0, 1, 8'hA5, 1, 0);
    chk("refill_ready", 32'(sd_byte_ready), 32'd1);
    rand_phase(40, 0, 60, 50, 0, 0);

    // Ping-pong crossings and wrap, with slow resume.
    rand_phase(800, 80, 60, 8, 0, 0);

    // Abort against a pending write with simultaneous ack/start/resume.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_wr) found = 1;
      else step(0, 0, 0, 1, 8'($urandom_range(255)), 0, 1);
    end
    chk("abort_setup", 32'(found), 32'd1);
    a_before = m_addr;
    step(0, 1, 1, 1, 8'h11, 1, 1);
    chk("abort_addr",  32'(addr_out_write), 32'(a_before));
    chk("abort_ready", 32'(sd_byte_ready), 32'd0);
    chk("abort_idle",  32'(active), 32'd0);
    step(0, 1, 0, 0, 8'h00, 0, 0);
    rand_phase(60, 70, 50, 30, 0, 0);

    // Reset for one cycle mid-stream, then restart.
    rand_phase(30, 90, 40, 30, 0, 0);
    step(1, 0, 0, 1, 8'h22, 1, 1);
    step(0, 1, 0, 0, 8'h00, 0, 0);
    rand_phase(100, 70, 50, 20, 0, 0);

    // Mixed random traffic including aborts and restarts.
    rand_phase(3000, 70, 50, 15, 2, 30);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
